// File: rtl/shared_reg_rr_arbiter.sv
// Shared NBITS-wide register with a four-way round-robin write arbiter.
//
// Four requesters compete to write one shared register. Ownership is granted
// round-robin starting after the most recent owner. An owner can hold
// ownership for up to MAX_HOLD consecutive granted cycles by asserting its
// lock bit. The grant vector and the register are both registered state.
//
// Parameters:
//   NBITS     width of the shared register and of each write-data lane
//   MAX_HOLD  max consecutive granted cycles per owner under lock (>= 1)
//
// Ports:
//   clk    in   1        clock, all state updates on the rising edge
//   rst    in   1        asynchronous active-high reset
//   req    in   4        req[i]: requester i wants to write
//   lock   in   4        lock[i]: requester i wants to keep ownership
//   wdata  in   4*NBITS  write data, requester i owns bits [i*NBITS +: NBITS]
//   grant  out  4        registered one-hot (or zero) grant vector
//   q      out  NBITS    shared register contents
//   busy   out  1        high while a requester owns the register

module shared_reg_rr_arbiter #(
  parameter int unsigned NBITS    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [3:0]         lock,
  input  logic [4*NBITS-1:0] wdata,
  output logic [3:0]         grant,
  output logic [NBITS-1:0]   q,
  output logic               busy
);

  // Hold counter counts 0 .. MAX_HOLD-1; keep at least one bit for MAX_HOLD=1.
  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StOwn
  } state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;       // current owner in StOwn, last owner in StIdle
  logic [HoldW-1:0] hold_cnt_q;  // extra cycles already granted under lock
  logic [3:0]       grant_q;
  logic [NBITS-1:0] q_q;

  // Split the flat write-data bus into per-requester lanes.
  logic [NBITS-1:0] wdata_lane [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wdata_lane[i] = wdata[i*NBITS +: NBITS];
    end
  end

  // Only the owner's lane is ever selected, so X on other lanes cannot reach q.
  logic [NBITS-1:0] owner_wdata;
  assign owner_wdata = wdata_lane[ptr_q];

  // Round-robin scan: ptr+1, ptr+2, ptr+3, then ptr itself last, so the
  // current owner is only re-selected when nobody else is requesting.
  logic       win_valid;
  logic [1:0] win_idx;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!win_valid && req[ptr_q + 2'(k)]) begin
        win_valid = 1'b1;
        win_idx   = ptr_q + 2'(k);
      end
    end
  end

  // Lock extends ownership only while the bound has not been reached.
  logic hold_ok;
  logic stay;

  assign hold_ok = (32'(hold_cnt_q) < (MAX_HOLD - 1));
  assign stay    = req[ptr_q] & lock[ptr_q] & hold_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd3;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      q_q        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_valid) begin
            grant_q    <= 4'b0001 << win_idx;
            ptr_q      <= win_idx;
            hold_cnt_q <= '0;
            state_q    <= StOwn;
          end else begin
            grant_q <= '0;
          end
        end
        StOwn: begin
          // The owner writes only on cycles where it still requests.
          if (req[ptr_q]) begin
            q_q <= owner_wdata;
          end
          if (stay) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end else if (win_valid) begin
            // Hand over in the same edge, no idle cycle between owners.
            grant_q    <= 4'b0001 << win_idx;
            ptr_q      <= win_idx;
            hold_cnt_q <= '0;
          end else begin
            grant_q    <= '0;
            hold_cnt_q <= '0;
            state_q    <= StIdle;
          end
        end
        default: begin
          grant_q    <= '0;
          hold_cnt_q <= '0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign q     = q_q;
  assign busy  = |grant_q;

  grant_onehot0_a : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

endmodule

// File: tb/tb_shared_reg_rr_arbiter.sv
module tb_shared_reg_rr_arbiter;

  localparam int unsigned NBITS    = 8;
  localparam int unsigned MAX_HOLD = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         req;
  logic [3:0]         lock;
  logic [4*NBITS-1:0] wdata;
  logic [3:0]         grant;
  logic [NBITS-1:0]   q;
  logic               busy;

  always #5 clk = ~clk;

  shared_reg_rr_arbiter #(
    .NBITS    (NBITS),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .grant (grant),
    .q     (q),
    .busy  (busy)
  );

  typedef struct {
    logic [3:0]       grant;
    logic [NBITS-1:0] q;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Lock bound: req=0011, lock=0001, lane0 = A0+k, lane1 = B1.
  localparam logic [3:0] LockG [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                       4'b0010, 4'b0001, 4'b0001, 4'b0001};
  localparam logic [7:0] LockQ [8] = '{8'h00, 8'hA1, 8'hA2, 8'hA3,
                                       8'hA4, 8'hB1, 8'hA6, 8'hA7};

  // Owner drop: owner 2 releases while requester 3 waits; lane3 = D3.
  localparam logic [3:0] DropR  [5] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0000};
  localparam logic [7:0] DropL2 [5] = '{8'hC2, 8'hC2, 8'hEE, 8'hEE, 8'hEE};
  localparam logic [3:0] DropG  [5] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0000};
  localparam logic [7:0] DropQ  [5] = '{8'h00, 8'hC2, 8'hC2, 8'hD3, 8'hD3};

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    lock  = '0;
    wdata = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus, queue what the DUT must show after the edge.
  task automatic apply(input logic [3:0] r, input logic [3:0] l,
                       input logic [4*NBITS-1:0] wd, input logic [3:0] eg,
                       input logic [NBITS-1:0] eq, input string tag);
    exp_t e;
    req     = r;
    lock    = l;
    wdata   = wd;
    e.grant = eg;
    e.q     = eq;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    n_checks++;
    if (grant !== 4'b0000 || q !== '0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got grant=%b q=%h busy=%b, expected 0000/00/0",
               grant, q, busy);
    end
    for (int k = 0; k < 2; k++) begin
      apply(4'b0001, 4'b0000, 32'h0000_00A5, 4'b0001, (k == 0) ? 8'h00 : 8'hA5,
            $sformatf("reset_pre[%0d]", k));
      e = sb.pop_front();
      n_checks++;
      if (grant !== e.grant || q !== e.q || busy !== (|e.grant)) begin
        n_errors++;
        $display("FAIL %s: got grant=%b q=%h busy=%b, expected grant=%b q=%h busy=%b",
                 e.tag, grant, q, busy, e.grant, e.q, |e.grant);
      end
    end
    // Assert reset between edges while the grant is active.
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_async_grant: got %b, expected 0000", grant);
    end
    n_checks++;
    if (q !== '0) begin
      n_errors++;
      $display("FAIL reset_async_q: got %h, expected 00", q);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async_busy: got %b, expected 0", busy);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (grant !== 4'b0000 || q !== '0) begin
      n_errors++;
      $display("FAIL reset_held: got grant=%b q=%h, expected 0000/00", grant, q);
    end
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply((k < 2) ? 4'b0001 : 4'b0000, 4'b0000,
            (k < 2) ? 32'h0000_00A5 : 32'h0000_005A,
            (k < 2) ? 4'b0001 : 4'b0000, (k == 0) ? 8'h00 : 8'hA5,
            $sformatf("single[%0d]", k));
      e = sb.pop_front();
      n_checks++;
      if (grant !== e.grant || q !== e.q || busy !== (|e.grant)) begin
        n_errors++;
        $display("FAIL %s: got grant=%b q=%h busy=%b, expected grant=%b q=%h busy=%b",
                 e.tag, grant, q, busy, e.grant, e.q, |e.grant);
      end
    end
  endtask

  task automatic test_fairness();
    exp_t       e;
    logic [7:0] eq;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      eq = (k == 0) ? 8'h00 : 8'(8'h11 * (((k - 1) % 4) + 1));
      apply(4'b1111, 4'b0000, 32'h4433_2211, 4'(4'b0001 << (k % 4)), eq,
            $sformatf("fair[%0d]", k));
      e = sb.pop_front();
      n_checks++;
      if (grant !== e.grant || q !== e.q || busy !== (|e.grant)) begin
        n_errors++;
        $display("FAIL %s: got grant=%b q=%h busy=%b, expected grant=%b q=%h busy=%b",
                 e.tag, grant, q, busy, e.grant, e.q, |e.grant);
      end
    end
  endtask

  task automatic test_lock_bound();
    exp_t e;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      apply(4'b0011, 4'b0001, {16'h0000, 8'hB1, 8'(8'hA0 + k)}, LockG[k], LockQ[k],
            $sformatf("lock[%0d]", k));
      e = sb.pop_front();
      n_checks++;
      if (grant !== e.grant || q !== e.q || busy !== (|e.grant)) begin
        n_errors++;
        $display("FAIL %s: got grant=%b q=%h busy=%b, expected grant=%b q=%h busy=%b",
                 e.tag, grant, q, busy, e.grant, e.q, |e.grant);
      end
    end
  endtask

  task automatic test_owner_drop();
    exp_t e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(DropR[k], 4'b0000, {8'hD3, DropL2[k], 16'h0000}, DropG[k], DropQ[k],
            $sformatf("drop[%0d]", k));
      e = sb.pop_front();
      n_checks++;
      if (grant !== e.grant || q !== e.q || busy !== (|e.grant)) begin
        n_errors++;
        $display("FAIL %s: got grant=%b q=%h busy=%b, expected grant=%b q=%h busy=%b",
                 e.tag, grant, q, busy, e.grant, e.q, |e.grant);
      end
    end
  endtask

  // Sole requester keeps the grant every cycle; other lanes carry X.
  task automatic test_sole_requester();
    exp_t               e;
    logic [4*NBITS-1:0] wd;
    logic [7:0]         v;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      v         = 8'(8'h10 + k);
      wd        = 'x;
      wd[15:8]  = v;
      apply((k < 5) ? 4'b0010 : 4'b0000, 4'b0000, wd,
            (k < 5) ? 4'b0010 : 4'b0000,
            (k == 0) ? 8'h00 : ((k < 5) ? v : 8'h14),
            $sformatf("sole[%0d]", k));
      e = sb.pop_front();
      n_checks++;
      if (grant !== e.grant || q !== e.q || busy !== (|e.grant)) begin
        n_errors++;
        $display("FAIL %s: got grant=%b q=%h busy=%b, expected grant=%b q=%h busy=%b",
                 e.tag, grant, q, busy, e.grant, e.q, |e.grant);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_lock_bound();
    test_owner_drop();
    test_sole_requester();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
